weight_pingpong_ctrl: RTL and testbench

Double-buffer (ping-pong) controller for the MAC-engine weight memory. It owns the two halves of the weight SRAM: buffer 0 at byte base 0 and buffer 1 at byte base PER_BUF_SIZE. It converts the 32-bit external loader stream into weight-SRAM write commands for the half being filled, and hands completed halves to the array control unit through a start/done handshake. Loading of layer N+1 overlaps with computation of layer N.

---
 rtl/weight_pingpong_ctrl.sv | 130 +++++++++++++
 tb/tb_weight_pingpong_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong controller for the two halves of the weight SRAM: packs loader beats into
// write commands for the filling half and hands completed halves to the array.
module weight_pingpong_ctrl #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned PER_BUF_SIZE = 2048,
    parameter int unsigned PORT_W       = 32,
    parameter int unsigned LEN_W        = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              ld_valid,
    input  logic [PORT_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PORT_W-1:0] wr_data,
    output logic              cons_valid,
    input  logic              cons_start,
    input  logic              cons_done,
    output logic [ADDR_W-1:0] cons_base,
    output logic [LEN_W-1:0]  cons_len,
    output logic [3:0]        buf_state,
    output logic              err_overflow,
    output logic              err_proto
);

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFilling = 2'd1,
        StFull    = 2'd2,
        StInUse   = 2'd3
    } buf_st_e;

    localparam logic [ADDR_W-1:0] BufSize = ADDR_W'(PER_BUF_SIZE);
    localparam logic [ADDR_W-1:0] LastOff = ADDR_W'(PER_BUF_SIZE - 4);
    localparam logic [ADDR_W-1:0] BeatBytes = ADDR_W'(4);

    buf_st_e           st_q [2];
    logic [LEN_W-1:0]  len_q [2];
    logic              fp_q;
    logic              cp_q;
    logic [ADDR_W-1:0] off_q;

    logic              fill_ok;
    logic              accept;
    logic              close;
    logic [ADDR_W-1:0] fill_base;

    always_comb begin
        fill_ok   = (st_q[fp_q] == StEmpty) || (st_q[fp_q] == StFilling);
        ld_ready  = fill_ok && !clear;
        accept    = ld_valid && ld_ready;
        close     = accept && (ld_last || (off_q == LastOff));
        fill_base = fp_q ? BufSize : '0;
    end

    assign cons_valid = (st_q[cp_q] == StFull);
    assign cons_base  = cp_q ? BufSize : '0;
    assign cons_len   = len_q[cp_q];
    assign buf_state  = {st_q[1], st_q[0]};

    // Fill side only touches EMPTY/FILLING buffers and consume side only FULL/IN_USE,
    // so the two indexed updates below never land on the same buffer in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= StEmpty;
                len_q[i] <= '0;
            end
            fp_q         <= 1'b0;
            cp_q         <= 1'b0;
            off_q        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            err_overflow <= 1'b0;
            err_proto    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= StEmpty;
                len_q[i] <= '0;
            end
            fp_q         <= 1'b0;
            cp_q         <= 1'b0;
            off_q        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            err_overflow <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            wr_en        <= accept;
            err_overflow <= close && !ld_last;
            err_proto    <= 1'b0;

            if (accept) begin
                wr_addr      <= fill_base + off_q;
                wr_data      <= ld_data;
                len_q[fp_q]  <= (st_q[fp_q] == StEmpty) ? LEN_W'(1) : len_q[fp_q] + 1'b1;
                if (close) begin
                    st_q[fp_q] <= StFull;
                    fp_q       <= ~fp_q;
                    off_q      <= '0;
                end else begin
                    st_q[fp_q] <= StFilling;
                    off_q      <= off_q + BeatBytes;
                end
            end

            // cons_done wins; a concurrent cons_start must be held to act on the new cp.
            if (cons_done) begin
                if (st_q[cp_q] == StInUse) begin
                    st_q[cp_q] <= StEmpty;
                    cp_q       <= ~cp_q;
                end else begin
                    err_proto <= 1'b1;
                end
            end else if (cons_start) begin
                if (st_q[cp_q] == StFull) begin
                    st_q[cp_q] <= StInUse;
                end else begin
                    err_proto <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Scoreboarded bench for weight_pingpong_ctrl: expected SRAM writes are queued as beats
// are driven and matched against wr_en/wr_addr/wr_data one cycle later.
module tb_weight_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        cons_valid;
    logic        cons_start = 1'b0;
    logic        cons_done = 1'b0;
    logic [11:0] cons_base;
    logic [9:0]  cons_len;
    logic [3:0]  buf_state;
    logic        err_overflow;
    logic        err_proto;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    weight_pingpong_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cons_valid   (cons_valid),
        .cons_start   (cons_start),
        .cons_done    (cons_done),
        .cons_base    (cons_base),
        .cons_len     (cons_len),
        .buf_state    (buf_state),
        .err_overflow (err_overflow),
        .err_proto    (err_proto)
    );

    always #5 clk = ~clk;

    // Advance one cycle and reconcile the write port with the scoreboard.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    bad++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end else if (exp_q.size() != 0) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL missing_write: wr_en=%b, required addr=%h data=%h",
                     wr_en, e.addr, e.data);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic [11:0] a);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        #1;
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: got ld_ready=%b, required 1 (addr %h)", ld_ready, a);
        end
        exp_q.push_back('{addr: a, data: d});
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        beat(32'h11, 1'b0, 12'h000);
        beat(32'h22, 1'b0, 12'h004);
        reset = 1'b1;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, cons_valid, cons_base, cons_len, buf_state,
             err_overflow, err_proto} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h cv=%b base=%h len=%0d st=%h ov=%b pe=%b, required all 0",
                     wr_en, wr_addr, wr_data, cons_valid, cons_base, cons_len, buf_state,
                     err_overflow, err_proto);
        end
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ld_ready: got %b, required 1", ld_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        beat(32'h33, 1'b0, 12'h000);
        do_clear();
    endtask

    task automatic test_short_layer();
        beat(32'hA, 1'b0, 12'h000);
        beat(32'hB, 1'b0, 12'h004);
        beat(32'hC, 1'b1, 12'h008);
        total++;
        if (buf_state !== 4'h2 || cons_valid !== 1'b1 || cons_base !== 12'h000 ||
            cons_len !== 10'd3) begin
            bad++;
            $display("FAIL short_layer: got st=%h cv=%b base=%h len=%0d, required st=2 cv=1 base=000 len=3",
                     buf_state, cons_valid, cons_base, cons_len);
        end
        beat(32'hD, 1'b0, 12'h800);
        // Clear with a beat presented: it must not be accepted.
        ld_valid = 1'b1;
        ld_data  = 32'hE;
        clear    = 1'b1;
        #1;
        total++;
        if (ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_ready: got ld_ready=%b, required 0", ld_ready);
        end
        step();
        clear    = 1'b0;
        ld_valid = 1'b0;
        total++;
        if (buf_state !== 4'h0 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL clear_filling: got st=%h wr_en=%b, required st=0 wr_en=0",
                     buf_state, wr_en);
        end
    endtask

    task automatic test_overflow();
        int n_err = 0;
        for (int i = 0; i < 513; i++) begin
            beat(32'h1000 + i, 1'b0, (i < 512) ? 12'(i * 4) : 12'h800);
            if (err_overflow === 1'b1) n_err++;
            if (i == 511) begin
                total++;
                if (err_overflow !== 1'b1 || buf_state[1:0] !== 2'd2 || cons_len !== 10'd512) begin
                    bad++;
                    $display("FAIL overflow_close: got ov=%b st=%h len=%0d, required ov=1 st0=2 len=512",
                             err_overflow, buf_state, cons_len);
                end
            end
        end
        total++;
        if (n_err != 1 || buf_state !== 4'h6) begin
            bad++;
            $display("FAIL overflow_pulse: got pulses=%0d st=%h, required pulses=1 st=6",
                     n_err, buf_state);
        end
        do_clear();
    endtask

    task automatic test_back_pressure();
        beat(32'h21, 1'b0, 12'h000);
        beat(32'h22, 1'b1, 12'h004);
        beat(32'h23, 1'b0, 12'h800);
        beat(32'h24, 1'b1, 12'h804);
        total++;
        if (buf_state !== 4'hA || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL both_full: got st=%h ld_ready=%b, required st=A ld_ready=0",
                     buf_state, ld_ready);
        end
        // Offered beats while stalled must produce no write (scoreboard stays empty).
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD;
        step();
        step();
        ld_valid   = 1'b0;
        cons_start = 1'b1;
        step();
        cons_start = 1'b0;
        total++;
        if (buf_state !== 4'hB || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_in_use: got st=%h ld_ready=%b, required st=B ld_ready=0",
                     buf_state, ld_ready);
        end
        cons_done = 1'b1;
        step();
        cons_done = 1'b0;
        total++;
        if (buf_state !== 4'h8 || ld_ready !== 1'b1 || cons_base !== 12'h800 ||
            cons_valid !== 1'b1 || cons_len !== 10'd2) begin
            bad++;
            $display("FAIL done_release: got st=%h rdy=%b base=%h cv=%b len=%0d, required st=8 rdy=1 base=800 cv=1 len=2",
                     buf_state, ld_ready, cons_base, cons_valid, cons_len);
        end
        beat(32'h25, 1'b0, 12'h000);
        do_clear();
    endtask

    task automatic test_proto();
        cons_start = 1'b1;
        step();
        cons_start = 1'b0;
        total++;
        if (err_proto !== 1'b1 || buf_state !== 4'h0) begin
            bad++;
            $display("FAIL proto_start_empty: got pe=%b st=%h, required pe=1 st=0",
                     err_proto, buf_state);
        end
        step();
        total++;
        if (err_proto !== 1'b0) begin
            bad++;
            $display("FAIL proto_pulse_width: got pe=%b, required 0", err_proto);
        end
        beat(32'h31, 1'b1, 12'h000);
        cons_done = 1'b1;
        step();
        cons_done = 1'b0;
        total++;
        if (err_proto !== 1'b1 || buf_state !== 4'h2) begin
            bad++;
            $display("FAIL proto_done_full: got pe=%b st=%h, required pe=1 st=2",
                     err_proto, buf_state);
        end
        do_clear();
    endtask

    task automatic test_simultaneous();
        beat(32'h41, 1'b1, 12'h000);
        cons_start = 1'b1;
        step();
        cons_start = 1'b0;
        beat(32'h42, 1'b0, 12'h800);
        cons_done = 1'b1;
        beat(32'h43, 1'b1, 12'h804);
        cons_done = 1'b0;
        total++;
        if (buf_state !== 4'h8 || cons_valid !== 1'b1 || cons_base !== 12'h800 ||
            cons_len !== 10'd2 || err_proto !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous: got st=%h cv=%b base=%h len=%0d pe=%b, required st=8 cv=1 base=800 len=2 pe=0",
                     buf_state, cons_valid, cons_base, cons_len, err_proto);
        end
        do_clear();
    endtask

    initial begin
        test_reset();
        test_short_layer();
        test_overflow();
        test_back_pressure();
        test_proto();
        test_simultaneous();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
